piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/shift_pkg.sv | 11 +
 rtl/bit_counter.sv | 27 ++
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the parallel-to-serial shifter family.
package shift_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_counter.sv
// Modulo-MODULUS up counter with synchronous clear, enable and terminal count.
module bit_counter #(
   parameter  int unsigned MODULUS = 4,
   localparam int unsigned CW      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   // Wraps explicitly at MODULUS-1 so non-power-of-two widths stay in range.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en) begin
         if (tc) count <= '0;
         else    count <= count + CW'(1);
      end
   end

   always_comb begin
      tc = (count == CW'(MODULUS - 1));
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load port and frame markers.
module piso_serializer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_par,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_start,
   output logic             frame_done
);

   localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam bit          MSB = (MSB_FIRST != 0);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_shifted;
   logic             head;
   logic [CW-1:0]    count;
   logic             tc;
   logic             accept;

   always_comb begin
      accept = load_valid & load_ready;
   end

   // Counter restarts on every accepted word and on reset.
   bit_counter #(
      .MODULUS (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .clr   (rst | accept),
      .en    (state == SHIFT),
      .count (count),
      .tc    (tc)
   );

   always_comb begin
      head          = MSB ? shreg[WIDTH-1] : shreg[0];
      shreg_shifted = MSB ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst)                 shreg <= '0;
      else if (accept)         shreg <= din_par;
      else if (state == SHIFT) shreg <= shreg_shifted;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: an accept in the last-bit cycle keeps shifting with no gap.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (tc && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode only registered state, counter and shift register.
   always_comb begin
      load_ready  = 1'b0;
      dout        = 1'b0;
      dout_valid  = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
         end
         SHIFT: begin
            dout        = head;
            dout_valid  = 1'b1;
            frame_start = (count == '0);
            frame_done  = tc;
            load_ready  = tc;
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a frame-position model.
module tb_piso_serializer;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din_par;
   logic         load_valid;

   logic m_ready, m_dout, m_valid, m_start, m_done;
   logic l_ready, l_dout, l_valid, l_start, l_done;

   int checks = 0;
   int errors = 0;

   // Reference model: a frame is "active" with a bit position 0..W-1.
   bit           mdl_active = 1'b0;
   int           mdl_pos    = 0;
   logic [W-1:0] mdl_word   = '0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .din_par(din_par), .load_valid(load_valid),
      .load_ready(m_ready), .dout(m_dout), .dout_valid(m_valid),
      .frame_start(m_start), .frame_done(m_done)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .din_par(din_par), .load_valid(load_valid),
      .load_ready(l_ready), .dout(l_dout), .dout_valid(l_valid),
      .frame_start(l_start), .frame_done(l_done)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      logic e_ready, e_valid, e_start, e_done, e_msb, e_lsb;
      e_ready = !mdl_active || (mdl_pos == W - 1);
      e_valid = mdl_active;
      e_start = mdl_active && (mdl_pos == 0);
      e_done  = mdl_active && (mdl_pos == W - 1);
      e_msb   = mdl_active ? mdl_word[W - 1 - mdl_pos] : 1'b0;
      e_lsb   = mdl_active ? mdl_word[mdl_pos] : 1'b0;
      check("msb_ready", m_ready, e_ready);
      check("msb_valid", m_valid, e_valid);
      check("msb_start", m_start, e_start);
      check("msb_done",  m_done,  e_done);
      check("msb_dout",  m_dout,  e_msb);
      check("lsb_ready", l_ready, e_ready);
      check("lsb_valid", l_valid, e_valid);
      check("lsb_start", l_start, e_start);
      check("lsb_done",  l_done,  e_done);
      check("lsb_dout",  l_dout,  e_lsb);
   endtask

   // One clock: drive at negedge, compare against the model, then advance it at posedge.
   task automatic step(input logic r, input logic lv, input logic [W-1:0] d);
      bit acc;
      @(negedge clk);
      rst        = r;
      load_valid = lv;
      din_par    = d;
      check_model();
      acc = lv && (!mdl_active || mdl_pos == W - 1);
      @(posedge clk);
      if (r) begin
         mdl_active = 1'b0;
         mdl_pos    = 0;
      end else if (acc) begin
         mdl_active = 1'b1;
         mdl_pos    = 0;
         mdl_word   = d;
      end else if (mdl_active) begin
         if (mdl_pos == W - 1) mdl_active = 1'b0;
         else                  mdl_pos++;
      end
      #1;
   endtask

   initial begin
      logic [0:3] seq_msb;
      logic [0:3] seq_lsb;
      logic [0:3] seq_rst;
      seq_msb    = 4'b1011;
      seq_lsb    = 4'b1101;
      seq_rst    = 4'b0110;
      rst        = 1'b1;
      load_valid = 1'b0;
      din_par    = '0;

      // Reset for two cycles.
      step(1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h0);
      check("rst_ready", m_ready, 1'b1);
      check("rst_dout",  m_dout,  1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_start", m_start, 1'b0);
      check("rst_done",  m_done,  1'b0);

      // Single word 1011 in both orders.
      step(1'b0, 1'b1, 4'b1011);
      for (int i = 0; i < 4; i++) begin
         check("single_msb_dout", m_dout, seq_msb[i]);
         check("single_lsb_dout", l_dout, seq_lsb[i]);
         check("single_start", m_start, (i == 0));
         check("single_done",  m_done,  (i == 3));
         step(1'b0, 1'b0, 4'h0);
      end
      check("single_idle_valid", m_valid, 1'b0);
      check("single_idle_ready", m_ready, 1'b1);

      // Back-to-back: 0100 offered continuously, taken only in the last-bit cycle.
      step(1'b0, 1'b1, 4'b1011);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0100);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0);

      // Stall: offers during bits 1-3 must be ignored.
      step(1'b0, 1'b1, 4'b1010);
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", m_ready, 1'b0);
         step(1'b0, 1'b1, 4'b0000);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0);

      // Mid-frame reset, then a fresh word.
      step(1'b0, 1'b1, 4'b1001);
      step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 4'b1111);
      check("midrst_valid", m_valid, 1'b0);
      check("midrst_done",  m_done,  1'b0);
      check("midrst_ready", m_ready, 1'b1);
      step(1'b0, 1'b1, 4'b0110);
      for (int i = 0; i < 4; i++) begin
         check("midrst_msb_dout", m_dout, seq_rst[i]);
         step(1'b0, 1'b0, 4'h0);
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              W'($urandom));
      end
      step(1'b0, 1'b0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
